fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle PC/instruction-memory fetch path of the 5-stage core.
- Decouples fetch from decode with a prefetch queue and a request/grant/response instruction-memory interface. The memory may have variable latency and accept multiple outstanding requests.
- Handles branch/jump redirects from EX by flushing the queue and discarding in-flight responses.
- Drives the IF/ID register inputs (instr, pc, pc+4) with a valid/ready handshake toward decode.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: prefetching instruction fetch with a credit-limited imem request/response
// interface, redirect flush with stale-response discard, and a valid/ready head toward decode.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH + 1),
  localparam int PW = $clog2(QDEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_4_o,
  input  logic            instr_ready_i,
  output logic [CW-1:0]   occupancy_o
);
  logic [XLEN-1:0] fetchPc, respPc, redirTarget;
  logic [CW-1:0] outstanding, discardCnt, count;
  logic [PW-1:0] rdPtr, wrPtr;
  logic [31:0] qInstr [QDEPTH];
  logic [XLEN-1:0] qPc [QDEPTH];
  logic grant, rsp, push, pop, unusedAlign;

  assign redirTarget = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unusedAlign = ^redirect_pc_i[1:0];
  // Credits cover both queued entries and requests still in flight, so a push never hits a full queue.
  assign imem_req_o = rst && !redirect_i && (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(QDEPTH));
  assign imem_addr_o = fetchPc;
  assign grant = imem_req_o && imem_gnt_i;
  assign rsp = imem_rvalid_i && outstanding != '0;
  assign push = rsp && discardCnt == '0 && !redirect_i;
  assign instr_valid_o = count != '0 && !redirect_i;
  assign pop = instr_valid_o && instr_ready_i;
  assign instr_o = count != '0 ? qInstr[rdPtr] : '0;
  assign pc_o = count != '0 ? qPc[rdPtr] : '0;
  assign pc_4_o = pc_o + XLEN'(4);
  assign occupancy_o = count;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetchPc <= RESET_PC;
      respPc <= RESET_PC;
      outstanding <= '0;
      discardCnt <= '0;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (redirect_i) begin
      // Everything still in flight is stale, including a response landing right now.
      fetchPc <= redirTarget;
      respPc <= redirTarget;
      outstanding <= outstanding - CW'(rsp);
      discardCnt <= outstanding - CW'(rsp);
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (grant) fetchPc <= fetchPc + XLEN'(4);
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
      if (rsp && discardCnt != '0) discardCnt <= discardCnt - CW'(1);
      if (push) respPc <= respPc + XLEN'(4);
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end

  always_ff @(posedge clk)
    if (push) begin
      qInstr[wrPtr] <= imem_rdata_i;
      qPc[wrPtr] <= respPc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-configurable in-order memory model.
module tb_fetch_unit;
  logic clk = 0, rst = 1, redirect = 0, gnt = 1, rvalid = 0, instrReady = 1;
  logic [31:0] redirectPc = 0, addr, rdata = 0, instrO, pcO, pc4O;
  logic req, instrValid;
  logic [2:0] occupancy;
  int tests = 0, fails = 0, lat = 1, cyc = 0;
  logic [31:0] expPc = 0;

  typedef struct { logic [31:0] a; int due; } pend_t;
  pend_t pend[$];
  logic acc = 0;
  logic [31:0] accAddr = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(instrValid), .instr_o(instrO), .pc_o(pcO), .pc_4_o(pc4O),
    .instr_ready_i(instrReady), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // In-order memory: a request granted at edge k responds in the cycle ending at edge k+lat.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (!rst) begin
      pend.delete();
      rvalid = 0;
    end else begin
      if (acc) pend.push_back('{accAddr, cyc + lat - 1});
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        rvalid = 1;
        rdata = instrOf(pend[0].a);
        void'(pend.pop_front());
      end else rvalid = 0;
    end
    @(negedge clk);
    acc = req && gnt;
    accAddr = addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk); #2;
  endtask

  task automatic smp();
    @(negedge clk);
    chk("occ_bound", 32'(occupancy <= 3'd4), 32'd1);
    if (instrValid && instrReady) begin
      chk("stream_pc", pcO, expPc);
      chk("stream_instr", instrO, instrOf(expPc));
      chk("stream_pc4", pc4O, expPc + 32'd4);
      expPc += 32'd4;
    end
  endtask

  task automatic pulseReset();
    go(); rst = 0; redirect = 0; expPc = 0; smp();
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(instrValid), 0);
    chk("rst_instr", instrO, 0);
    chk("rst_occ", 32'(occupancy), 0);
    go(); rst = 1;
  endtask

  initial begin
    // sequential fetch
    pulseReset();
    smp(); chk("seq_addr0", addr, 32'h0); chk("seq_req0", 32'(req), 1); chk("seq_valid0", 32'(instrValid), 0);
    go(); smp(); chk("seq_addr1", addr, 32'h4); chk("seq_valid1", 32'(instrValid), 0);
    go(); smp(); chk("seq_first_valid", 32'(instrValid), 1); chk("seq_first_pc", pcO, 32'h0);
    chk("seq_first_pc4", pc4O, 32'h4); chk("seq_addr2", addr, 32'h8);
    repeat (5) begin go(); smp(); end
    // backpressure
    go(); instrReady = 0; smp(); chk("bp_head", pcO, 32'h18); chk("bp_occ1", 32'(occupancy), 1);
    go(); smp();
    go(); smp(); chk("bp_req_drop", 32'(req), 0); chk("bp_occ3", 32'(occupancy), 3);
    repeat (7) begin go(); smp(); chk("bp_occ_full", 32'(occupancy), 4); chk("bp_req_hold", 32'(req), 0); end
    go(); instrReady = 1; smp(); chk("bp_drain_pc", pcO, 32'h18);
    go(); smp(); chk("bp_resume_req", 32'(req), 1); chk("bp_resume_addr", addr, 32'h28);
    repeat (6) begin go(); smp(); end
    // redirect with two in-flight requests, 3-cycle memory
    lat = 3;
    pulseReset();
    smp(); chk("rd_addr0", addr, 32'h0);
    go(); smp(); chk("rd_addr1", addr, 32'h4);
    go(); redirect = 1; redirectPc = 32'h100; expPc = 32'h100; smp();
    chk("rd_req_drop", 32'(req), 0); chk("rd_valid_drop", 32'(instrValid), 0);
    go(); redirect = 0; smp(); chk("rd_new_addr", addr, 32'h100); chk("rd_new_req", 32'(req), 1);
    go(); smp(); chk("rd_addr_next", addr, 32'h104); chk("rd_stale1", 32'(instrValid), 0);
    go(); smp(); chk("rd_stale_occ", 32'(occupancy), 0);
    go(); smp(); chk("rd_wait", 32'(instrValid), 0);
    go(); smp(); chk("rd_target_valid", 32'(instrValid), 1); chk("rd_target_pc", pcO, 32'h100);
    repeat (4) begin go(); smp(); end
    // redirect coincident with a response while two entries are queued
    lat = 1; instrReady = 0;
    pulseReset();
    smp();
    go(); smp();
    go(); smp(); chk("co_occ1", 32'(occupancy), 1);
    go(); redirect = 1; redirectPc = 32'h42; instrReady = 1; expPc = 32'h40; smp();
    chk("co_occ2", 32'(occupancy), 2); chk("co_valid_masked", 32'(instrValid), 0); chk("co_req_masked", 32'(req), 0);
    go(); redirect = 0; smp(); chk("co_occ_clear", 32'(occupancy), 0); chk("co_valid0", 32'(instrValid), 0);
    chk("co_addr", addr, 32'h40);
    go(); smp(); chk("co_valid1", 32'(instrValid), 0);
    go(); smp(); chk("co_target_valid", 32'(instrValid), 1); chk("co_target_pc", pcO, 32'h40);
    // stalled grant
    pulseReset();
    smp();
    go(); smp();
    go(); gnt = 0; smp(); chk("sg_addr", addr, 32'h8); chk("sg_req", 32'(req), 1);
    repeat (4) begin go(); smp(); chk("sg_addr_hold", addr, 32'h8); chk("sg_req_hold", 32'(req), 1); end
    go(); gnt = 1; smp(); chk("sg_addr_grant", addr, 32'h8);
    go(); smp(); chk("sg_addr_adv", addr, 32'hC); chk("sg_gap", 32'(instrValid), 0);
    go(); smp(); chk("sg_valid", 32'(instrValid), 1); chk("sg_pc", pcO, 32'h8);
    // wrap-around and mid-stream reset
    go(); redirect = 1; redirectPc = 32'hFFFF_FFFC; expPc = 32'hFFFF_FFFC; smp();
    chk("wr_valid_masked", 32'(instrValid), 0);
    go(); redirect = 0; smp(); chk("wr_addr", addr, 32'hFFFF_FFFC);
    go(); smp(); chk("wr_addr_wrap", addr, 32'h0);
    go(); smp(); chk("wr_pc", pcO, 32'hFFFF_FFFC); chk("wr_pc4", pc4O, 32'h0);
    go(); smp(); chk("wr_pc_next", pcO, 32'h0); chk("wr_pc4_next", pc4O, 32'h4);
    go(); smp(); chk("wr_pre_rst_occ", 32'(occupancy), 1);
    go(); rst = 0; expPc = 0; smp();
    chk("mr_occ", 32'(occupancy), 0); chk("mr_valid", 32'(instrValid), 0); chk("mr_req", 32'(req), 0);
    go(); smp();
    go(); rst = 1; smp(); chk("mr_restart_addr", addr, 32'h0); chk("mr_restart_req", 32'(req), 1);
    go(); smp();
    go(); smp(); chk("mr_first_valid", 32'(instrValid), 1); chk("mr_first_pc", pcO, 32'h0);
    repeat (3) begin go(); smp(); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
